mesh_4x4: RTL and testbench
===========================

# mesh_4x4

4x4 mesh network-on-chip: 16 identical 5-port routers (local PE, X+, X-, Y+, Y-) connected in a grid, each with a processing-element (PE) injection/ejection port. Packets carry source coordinates plus direction/hop fields. They are routed dimension-ordered (X then Y), one hop per cycle, and delivered unmodified to the destination PE. The block is the top-level interconnect between the 16 PEs.

## Interface
- No parameters.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low.
- polarity  out  1  cycle-parity indicator.
- For each router k = 0..15, where k = y*4 + x and (x,y) are the router's mesh coordinates:
  - pesi_rk  in  1  PE send valid.
  - pedi_rk  in  64  PE send data.
  - peri_rk  out  1  router ready to accept from PE.
  - pero_rk  in  1  PE ready to receive.
  - pedo_rk  out  64  data delivered to PE.
  - peso_rk  out  1  delivery valid.

## Operation
- Packet format:
  - [63] reserved, 0.
  - [62:61] dir: dir[1] = 1 means +X, otherwise -X; dir[0] = 1 means +Y, otherwise -Y.
  - [60:56] reserved.
  - [55:52] hop_x; [51:48] hop_y.
  - [47:40] src_x; [39:32] src_y.
  - [31:0] payload.
- Destination:
  - dest_x = dir[1] ? src_x + hop_x : src_x - hop_x.
  - dest_y = dir[0] ? src_y + hop_y : src_y - hop_y.
  - Both computed 8-bit, modulo 256.
- Packets are never modified in flight. pedo equals the injected pedi bit-for-bit.
- Each router input port (Local, X-, X+, Y-, Y+) has a one-entry 64-bit buffer with a valid bit. A buffer accepts only when it is empty at the start of the cycle.
- Routing decision per buffered packet, given router (x,y):
  - dest_x > x: route to X+.
  - dest_x < x: route to X-.
  - Otherwise, dest_y > y: route to Y+.
  - Otherwise, dest_y < y: route to Y-.
  - Otherwise: route to Local.
- Per output port, one winner per cycle among requesting inputs whose downstream buffer is empty. Local output additionally requires pero_rk = 1.
- Arbitration is fixed priority Local, X-, X+, Y-, Y+, unless the round-robin build option is enabled (see Configuration). Losers hold.
- Injection:
  - peri_rk = Local input buffer empty.
  - When pesi_rk = 1 and peri_rk = 1, pedi_rk is captured at the edge.
  - pesi_rk while peri_rk = 0 is ignored; the packet is lost and this is the PE's responsibility.
  - If dest_x > 3 or dest_y > 3, the packet is discarded on capture. It is never delivered and the buffer stays empty.
- Ejection: the Local output register drives pedo_rk/peso_rk. peso_rk is high for exactly one cycle per delivered packet.
- polarity toggles every cycle.

## Timing
- On reset = 0 at an edge:
  - All buffers are emptied.
  - peso_rk = 0, pedo_rk = 0, peri_rk = 1, polarity = 0.
- Reset mid-operation drops all in-flight packets.
- Latency for a packet captured at edge T, with H = |dest_x - src_x| + |dest_y - src_y|:
  - Without contention it sits in the buffer H hops away after edge T+H.
  - It is in the output register after edge T+H+1; peso_rk is high during that following cycle. Total latency is H+1 cycles.
  - Zero-hop (self) packets deliver after edge T+1.
- Each contention loss or pero_rk = 0 cycle adds one cycle. No packet is dropped for backpressure.
- A buffer freed at edge E can accept a new packet at edge E+1. Each link carries at most one packet per 2 cycles.
- Maximum delivery rate is 1 packet per cycle per PE, when the Local output and upstream buffers alternate.

## Configuration
- MESH_RR_ARB_EN:
  - Defined: each output arbiter is round-robin. Its pointer moves to the port after the last winner and resets to Local.
  - Undefined: fixed priority Local > X- > X+ > Y- > Y+.

## Test plan
- Single packet, reset released:
  - Stimulus: r12 injects 64'h4023_0003_3333_3333.
  - Response: peso_r2 high exactly once, 6 cycles after capture, with pedo_r2 = 64'h4023_0003_3333_3333. No other peso asserts.
- Gather to r2: all routers except r2 inject simultaneously toward (2,0). Examples:
  - r0: 64'h4020_0000_0000_0000.
  - r15: 64'h0013_0303_FFFF_FFFF.
  - Response: 15 distinct packets delivered at r2, at most one per cycle, all unmodified, none elsewhere. Repeat with MESH_RR_ARB_EN.
- Backpressure:
  - Stimulus: hold pero_r5 = 0; r0 sends 64'h6011_0000_5555_5555.
  - Response: no peso_r5. After pero_r5 = 1, delivery within 1 cycle.
- Out-of-range:
  - Stimulus: r3 sends dir = 10, hop_x = 1 (dest_x = 4).
  - Response: no delivery anywhere; peri_r3 = 1 the next cycle.
- Self-send and reset:
  - Stimulus: r10 sends hop 00.
  - Response: peso_r10 after 1 cycle.
  - Stimulus: inject a 6-hop packet, assert reset after 2 cycles.
  - Response: never delivered; all peri = 1.

Source files
------------

// File: rtl/mesh_4x4.sv
// mesh_4x4 -- 4x4 mesh network-on-chip with 16 five-port routers.
//
// Router k sits at (x,y) = (k % 4, k / 4). Every router has five one-entry
// input buffers (Local, X-, X+, Y-, Y+). Packets move one hop per cycle,
// X first and then Y, and reach the destination PE unmodified.
//
// Ports:
//   clk, reset     rising-edge clock; synchronous active-low reset
//   polarity       toggles every cycle, 0 while in reset
//   pesi_rk/pedi_rk/peri_rk   PE -> router injection (valid/data/ready)
//   pero_rk/pedo_rk/peso_rk   router -> PE ejection (ready/data/valid)
//
// Handshake: injection is valid/ready. pedi_rk is captured at an edge where
// pesi_rk and peri_rk are both high. peri_rk is high exactly when the Local
// input buffer is empty. On ejection, pero_rk gates the move into the output
// register, and peso_rk then pulses for one cycle per delivered packet.
//
// Build option: define MESH_RR_ARB_EN for round-robin output arbiters.
// Without it, each output uses fixed priority Local > X- > X+ > Y- > Y+.
module mesh_4x4 (
  input  logic clk,
  input  logic reset,
  output logic polarity,
  input  logic pesi_r0,  input  logic [63:0] pedi_r0,  output logic peri_r0,
  input  logic pero_r0,  output logic [63:0] pedo_r0,  output logic peso_r0,
  input  logic pesi_r1,  input  logic [63:0] pedi_r1,  output logic peri_r1,
  input  logic pero_r1,  output logic [63:0] pedo_r1,  output logic peso_r1,
  input  logic pesi_r2,  input  logic [63:0] pedi_r2,  output logic peri_r2,
  input  logic pero_r2,  output logic [63:0] pedo_r2,  output logic peso_r2,
  input  logic pesi_r3,  input  logic [63:0] pedi_r3,  output logic peri_r3,
  input  logic pero_r3,  output logic [63:0] pedo_r3,  output logic peso_r3,
  input  logic pesi_r4,  input  logic [63:0] pedi_r4,  output logic peri_r4,
  input  logic pero_r4,  output logic [63:0] pedo_r4,  output logic peso_r4,
  input  logic pesi_r5,  input  logic [63:0] pedi_r5,  output logic peri_r5,
  input  logic pero_r5,  output logic [63:0] pedo_r5,  output logic peso_r5,
  input  logic pesi_r6,  input  logic [63:0] pedi_r6,  output logic peri_r6,
  input  logic pero_r6,  output logic [63:0] pedo_r6,  output logic peso_r6,
  input  logic pesi_r7,  input  logic [63:0] pedi_r7,  output logic peri_r7,
  input  logic pero_r7,  output logic [63:0] pedo_r7,  output logic peso_r7,
  input  logic pesi_r8,  input  logic [63:0] pedi_r8,  output logic peri_r8,
  input  logic pero_r8,  output logic [63:0] pedo_r8,  output logic peso_r8,
  input  logic pesi_r9,  input  logic [63:0] pedi_r9,  output logic peri_r9,
  input  logic pero_r9,  output logic [63:0] pedo_r9,  output logic peso_r9,
  input  logic pesi_r10, input  logic [63:0] pedi_r10, output logic peri_r10,
  input  logic pero_r10, output logic [63:0] pedo_r10, output logic peso_r10,
  input  logic pesi_r11, input  logic [63:0] pedi_r11, output logic peri_r11,
  input  logic pero_r11, output logic [63:0] pedo_r11, output logic peso_r11,
  input  logic pesi_r12, input  logic [63:0] pedi_r12, output logic peri_r12,
  input  logic pero_r12, output logic [63:0] pedo_r12, output logic peso_r12,
  input  logic pesi_r13, input  logic [63:0] pedi_r13, output logic peri_r13,
  input  logic pero_r13, output logic [63:0] pedo_r13, output logic peso_r13,
  input  logic pesi_r14, input  logic [63:0] pedi_r14, output logic peri_r14,
  input  logic pero_r14, output logic [63:0] pedo_r14, output logic peso_r14,
  input  logic pesi_r15, input  logic [63:0] pedi_r15, output logic peri_r15,
  input  logic pero_r15, output logic [63:0] pedo_r15, output logic peso_r15
);

  // Port indices are shared by input buffers and output directions.
  localparam logic [2:0] P_L  = 3'd0;
  localparam logic [2:0] P_XM = 3'd1;
  localparam logic [2:0] P_XP = 3'd2;
  localparam logic [2:0] P_YM = 3'd3;
  localparam logic [2:0] P_YP = 3'd4;

  logic [15:0] pesi, pero;
  logic [63:0] pedi [16];

  logic [63:0] pkt_q [16][5], pkt_d [16][5];
  logic [4:0]  vld_q [16], vld_d [16];
  logic [63:0] pedo_q [16], pedo_d [16];
  logic [15:0] peso_q, peso_d;
  logic        polarity_q, polarity_d;
`ifdef MESH_RR_ARB_EN
  logic [2:0]  ptr_q [16][5], ptr_d [16][5];
  logic [2:0]  cand;
`endif

  logic [4:0]  req;
  logic        ok, hit;
  logic [2:0]  win, np;
  logic [3:0]  nb;
  logic [7:0]  rx, ry;
  logic [15:0] dst;

  // Destination {dest_x, dest_y}, each 8-bit modulo 256.
  function automatic logic [15:0] dest_of(input logic [63:0] pkt);
    logic [7:0] hx, hy;
    hx = {4'd0, pkt[55:52]};
    hy = {4'd0, pkt[51:48]};
    dest_of[15:8] = pkt[62] ? pkt[47:40] + hx : pkt[47:40] - hx;
    dest_of[7:0]  = pkt[61] ? pkt[39:32] + hy : pkt[39:32] - hy;
  endfunction

  // Dimension-ordered routing: resolve X fully before moving in Y.
  function automatic logic [2:0] route_of(input logic [63:0] pkt,
                                          input logic [7:0] x, input logic [7:0] y);
    logic [15:0] d;
    d = dest_of(pkt);
    if (d[15:8] > x)      route_of = P_XP;
    else if (d[15:8] < x) route_of = P_XM;
    else if (d[7:0] > y)  route_of = P_YP;
    else if (d[7:0] < y)  route_of = P_YM;
    else                  route_of = P_L;
  endfunction

  assign pesi = {pesi_r15, pesi_r14, pesi_r13, pesi_r12, pesi_r11, pesi_r10, pesi_r9, pesi_r8,
                 pesi_r7, pesi_r6, pesi_r5, pesi_r4, pesi_r3, pesi_r2, pesi_r1, pesi_r0};
  assign pero = {pero_r15, pero_r14, pero_r13, pero_r12, pero_r11, pero_r10, pero_r9, pero_r8,
                 pero_r7, pero_r6, pero_r5, pero_r4, pero_r3, pero_r2, pero_r1, pero_r0};
  assign pedi[0]  = pedi_r0;  assign pedi[1]  = pedi_r1;  assign pedi[2]  = pedi_r2;
  assign pedi[3]  = pedi_r3;  assign pedi[4]  = pedi_r4;  assign pedi[5]  = pedi_r5;
  assign pedi[6]  = pedi_r6;  assign pedi[7]  = pedi_r7;  assign pedi[8]  = pedi_r8;
  assign pedi[9]  = pedi_r9;  assign pedi[10] = pedi_r10; assign pedi[11] = pedi_r11;
  assign pedi[12] = pedi_r12; assign pedi[13] = pedi_r13; assign pedi[14] = pedi_r14;
  assign pedi[15] = pedi_r15;

  assign peri_r0  = ~vld_q[0][0];  assign peri_r1  = ~vld_q[1][0];  assign peri_r2  = ~vld_q[2][0];
  assign peri_r3  = ~vld_q[3][0];  assign peri_r4  = ~vld_q[4][0];  assign peri_r5  = ~vld_q[5][0];
  assign peri_r6  = ~vld_q[6][0];  assign peri_r7  = ~vld_q[7][0];  assign peri_r8  = ~vld_q[8][0];
  assign peri_r9  = ~vld_q[9][0];  assign peri_r10 = ~vld_q[10][0]; assign peri_r11 = ~vld_q[11][0];
  assign peri_r12 = ~vld_q[12][0]; assign peri_r13 = ~vld_q[13][0]; assign peri_r14 = ~vld_q[14][0];
  assign peri_r15 = ~vld_q[15][0];

  assign pedo_r0  = pedo_q[0];  assign pedo_r1  = pedo_q[1];  assign pedo_r2  = pedo_q[2];
  assign pedo_r3  = pedo_q[3];  assign pedo_r4  = pedo_q[4];  assign pedo_r5  = pedo_q[5];
  assign pedo_r6  = pedo_q[6];  assign pedo_r7  = pedo_q[7];  assign pedo_r8  = pedo_q[8];
  assign pedo_r9  = pedo_q[9];  assign pedo_r10 = pedo_q[10]; assign pedo_r11 = pedo_q[11];
  assign pedo_r12 = pedo_q[12]; assign pedo_r13 = pedo_q[13]; assign pedo_r14 = pedo_q[14];
  assign pedo_r15 = pedo_q[15];

  assign peso_r0  = peso_q[0];  assign peso_r1  = peso_q[1];  assign peso_r2  = peso_q[2];
  assign peso_r3  = peso_q[3];  assign peso_r4  = peso_q[4];  assign peso_r5  = peso_q[5];
  assign peso_r6  = peso_q[6];  assign peso_r7  = peso_q[7];  assign peso_r8  = peso_q[8];
  assign peso_r9  = peso_q[9];  assign peso_r10 = peso_q[10]; assign peso_r11 = peso_q[11];
  assign peso_r12 = peso_q[12]; assign peso_r13 = peso_q[13]; assign peso_r14 = peso_q[14];
  assign peso_r15 = peso_q[15];

  assign polarity = polarity_q;

  always_comb begin
    pkt_d      = pkt_q;
    vld_d      = vld_q;
    pedo_d     = pedo_q;
    peso_d     = '0;
    polarity_d = ~polarity_q;
`ifdef MESH_RR_ARB_EN
    ptr_d      = ptr_q;
    cand       = P_L;
`endif
    req = '0; ok = 1'b0; hit = 1'b0; win = P_L; np = P_L; nb = '0;
    rx = '0; ry = '0; dst = '0;
    for (int r = 0; r < 16; r++) begin
      rx = 8'(r % 4);
      ry = 8'(r / 4);
      for (int o = 0; o < 5; o++) begin
        req = '0;
        for (int i = 0; i < 5; i++)
          if (vld_q[r][i] && (route_of(pkt_q[r][i], rx, ry) == 3'(o))) req[i] = 1'b1;
        // Downstream must be empty at the start of the cycle; a neighbour's
        // buffer facing us is its opposite-direction input. Mesh edges are
        // never free, though XY routing never asks for them.
        ok = 1'b0; nb = 4'(r); np = P_L;
        case (o)
          0: ok = pero[r];
          1: begin nb = 4'(r - 1); np = P_XP; ok = (rx != 8'd0) && !vld_q[nb][P_XP]; end
          2: begin nb = 4'(r + 1); np = P_XM; ok = (rx != 8'd3) && !vld_q[nb][P_XM]; end
          3: begin nb = 4'(r - 4); np = P_YP; ok = (ry != 8'd0) && !vld_q[nb][P_YP]; end
          default: begin nb = 4'(r + 4); np = P_YM; ok = (ry != 8'd3) && !vld_q[nb][P_YM]; end
        endcase
        hit = 1'b0; win = P_L;
        // Scan from lowest precedence upward so the last match is the winner.
`ifdef MESH_RR_ARB_EN
        for (int k = 4; k >= 0; k--) begin
          cand = 3'((32'(ptr_q[r][o]) + k) % 5);
          if (ok && req[cand]) begin hit = 1'b1; win = cand; end
        end
`else
        for (int k = 4; k >= 0; k--)
          if (ok && req[k]) begin hit = 1'b1; win = 3'(k); end
`endif
        if (hit) begin
          vld_d[r][win] = 1'b0;
          if (o == 0) begin
            pedo_d[r] = pkt_q[r][win];
            peso_d[r] = 1'b1;
          end else begin
            pkt_d[nb][np] = pkt_q[r][win];
            vld_d[nb][np] = 1'b1;
          end
`ifdef MESH_RR_ARB_EN
          ptr_d[r][o] = 3'((32'(win) + 1) % 5);
`endif
        end
      end
      // Injection; out-of-mesh destinations are dropped at capture.
      if (!vld_q[r][P_L] && pesi[r]) begin
        dst = dest_of(pedi[r]);
        if ((dst[15:8] < 8'd4) && (dst[7:0] < 8'd4)) begin
          pkt_d[r][P_L] = pedi[r];
          vld_d[r][P_L] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 16; r++) begin
        vld_q[r]  <= '0;
        pedo_q[r] <= '0;
        for (int i = 0; i < 5; i++) begin
          pkt_q[r][i] <= '0;
`ifdef MESH_RR_ARB_EN
          ptr_q[r][i] <= P_L;
`endif
        end
      end
      peso_q     <= '0;
      polarity_q <= 1'b0;
    end else begin
      pkt_q      <= pkt_d;
      vld_q      <= vld_d;
      pedo_q     <= pedo_d;
      peso_q     <= peso_d;
      polarity_q <= polarity_d;
`ifdef MESH_RR_ARB_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mesh_4x4.sv
// tb_mesh_4x4 -- directed and randomized bench for mesh_4x4.
// Expected deliveries come from a reference model that computes each
// packet's destination router and hop count straight from its fields.
module tb_mesh_4x4;

  logic        clk = 1'b0;
  logic        reset;
  wire         polarity;
  logic [15:0] pesi, pero;
  logic [63:0] pedi [16];
  wire  [15:0] peri, peso;
  wire  [63:0] pedo [16];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int deliv_total = 0;
  int deliv_cnt [16];
  logic [67:0] exp_q [$];   // {dest router, packet}

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  mesh_4x4 dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .pesi_r0(pesi[0]), .pedi_r0(pedi[0]), .peri_r0(peri[0]), .pero_r0(pero[0]), .pedo_r0(pedo[0]), .peso_r0(peso[0]),
    .pesi_r1(pesi[1]), .pedi_r1(pedi[1]), .peri_r1(peri[1]), .pero_r1(pero[1]), .pedo_r1(pedo[1]), .peso_r1(peso[1]),
    .pesi_r2(pesi[2]), .pedi_r2(pedi[2]), .peri_r2(peri[2]), .pero_r2(pero[2]), .pedo_r2(pedo[2]), .peso_r2(peso[2]),
    .pesi_r3(pesi[3]), .pedi_r3(pedi[3]), .peri_r3(peri[3]), .pero_r3(pero[3]), .pedo_r3(pedo[3]), .peso_r3(peso[3]),
    .pesi_r4(pesi[4]), .pedi_r4(pedi[4]), .peri_r4(peri[4]), .pero_r4(pero[4]), .pedo_r4(pedo[4]), .peso_r4(peso[4]),
    .pesi_r5(pesi[5]), .pedi_r5(pedi[5]), .peri_r5(peri[5]), .pero_r5(pero[5]), .pedo_r5(pedo[5]), .peso_r5(peso[5]),
    .pesi_r6(pesi[6]), .pedi_r6(pedi[6]), .peri_r6(peri[6]), .pero_r6(pero[6]), .pedo_r6(pedo[6]), .peso_r6(peso[6]),
    .pesi_r7(pesi[7]), .pedi_r7(pedi[7]), .peri_r7(peri[7]), .pero_r7(pero[7]), .pedo_r7(pedo[7]), .peso_r7(peso[7]),
    .pesi_r8(pesi[8]), .pedi_r8(pedi[8]), .peri_r8(peri[8]), .pero_r8(pero[8]), .pedo_r8(pedo[8]), .peso_r8(peso[8]),
    .pesi_r9(pesi[9]), .pedi_r9(pedi[9]), .peri_r9(peri[9]), .pero_r9(pero[9]), .pedo_r9(pedo[9]), .peso_r9(peso[9]),
    .pesi_r10(pesi[10]), .pedi_r10(pedi[10]), .peri_r10(peri[10]), .pero_r10(pero[10]), .pedo_r10(pedo[10]), .peso_r10(peso[10]),
    .pesi_r11(pesi[11]), .pedi_r11(pedi[11]), .peri_r11(peri[11]), .pero_r11(pero[11]), .pedo_r11(pedo[11]), .peso_r11(peso[11]),
    .pesi_r12(pesi[12]), .pedi_r12(pedi[12]), .peri_r12(peri[12]), .pero_r12(pero[12]), .pedo_r12(pedo[12]), .peso_r12(peso[12]),
    .pesi_r13(pesi[13]), .pedi_r13(pedi[13]), .peri_r13(peri[13]), .pero_r13(pero[13]), .pedo_r13(pedo[13]), .peso_r13(peso[13]),
    .pesi_r14(pesi[14]), .pedi_r14(pedi[14]), .peri_r14(peri[14]), .pero_r14(pero[14]), .pedo_r14(pedo[14]), .peso_r14(peso[14]),
    .pesi_r15(pesi[15]), .pedi_r15(pedi[15]), .peri_r15(peri[15]), .pero_r15(pero[15]), .pedo_r15(pedo[15]), .peso_r15(peso[15])
  );

  // ---------------- reference model ----------------
  // Destination router index, or -1 when the packet leaves the mesh.
  function automatic int ref_dest(input logic [63:0] p);
    int sx, sy, hx, hy, dx, dy;
    sx = int'(p[47:40]); sy = int'(p[39:32]);
    hx = int'(p[55:52]); hy = int'(p[51:48]);
    dx = p[62] ? (sx + hx) % 256 : (sx - hx + 256) % 256;
    dy = p[61] ? (sy + hy) % 256 : (sy - hy + 256) % 256;
    if (dx > 3 || dy > 3) return -1;
    return dy * 4 + dx;
  endfunction

  function automatic int ref_hops(input logic [63:0] p);
    int d, sx, sy, dx, dy;
    d = ref_dest(p);
    sx = int'(p[47:40]); sy = int'(p[39:32]);
    dx = d % 4; dy = d / 4;
    return (dx > sx ? dx - sx : sx - dx) + (dy > sy ? dy - sy : sy - dy);
  endfunction

  function automatic logic [63:0] make_pkt(input int sx, input int sy, input int dx,
                                           input int dy, input logic [31:0] pay);
    logic px, py;
    px = (dx > sx) ? 1'b1 : (dx < sx) ? 1'b0 : 1'($urandom_range(0, 1));
    py = (dy > sy) ? 1'b1 : (dy < sy) ? 1'b0 : 1'($urandom_range(0, 1));
    return {1'b0, px, py, 5'd0, 4'(dx > sx ? dx - sx : sx - dx),
            4'(dy > sy ? dy - sy : sy - dy), 8'(sx), 8'(sy), pay};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pkt(input logic [63:0] p);
    int d;
    d = ref_dest(p);
    if (d >= 0) exp_q.push_back({4'(d), p});
  endtask

  always @(negedge clk) begin
    logic found;
    for (int r = 0; r < 16; r++) begin
      if (peso[r] === 1'b1) begin
        found = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (!found && exp_q[j] === {4'(r), pedo[r]}) begin
            found = 1'b1;
            exp_q.delete(j);
          end
        end
        check($sformatf("deliver_r%0d_%0h", r, pedo[r]), 64'(found), 64'd1);
        deliv_cnt[r]++;
        deliv_total++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic inject(input int r, input logic [63:0] p, output int cap);
    pesi[r] = 1'b1;
    pedi[r] = p;
    @(posedge clk); #1;
    cap = cyc;
    pesi[r] = 1'b0;
  endtask

  task automatic wait_peso(input int r, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (at < 0 && peso[r] === 1'b1) at = cyc;
    end
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cap, at, snap, snap2, d;
    logic [63:0] p;
    reset = 1'b0;
    pesi  = '0;
    pero  = '1;
    for (int r = 0; r < 16; r++) begin pedi[r] = '0; deliv_cnt[r] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_peri", 64'(peri), 64'hFFFF);
    check("rst_peso", 64'(peso), 64'h0);
    check("rst_polarity", 64'(polarity), 64'd0);
    check("rst_pedo_r7", pedo[7], 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("polarity_%0d", i), 64'(polarity), 64'(i % 2));
    end

    // Single packet r12 -> r2
    @(posedge clk); #1;
    p = 64'h4023_0003_3333_3333;
    check("single_dest", 64'(ref_dest(p)), 64'd2);
    expect_pkt(p);
    snap = deliv_total;
    inject(12, p, cap);
    wait_peso(2, 20, at);
    check("single_latency", 64'(at - cap), 64'(ref_hops(p) + 1));
    check("single_count", 64'(deliv_total - snap), 64'd1);
    check("single_drained", 64'(exp_q.size()), 64'd0);

    // Gather: every router except r2 targets (2,0)
    @(posedge clk); #1;
    check("gather_peri", 64'(peri), 64'hFFFF);
    snap = deliv_total; snap2 = deliv_cnt[2];
    for (int r = 0; r < 16; r++) begin
      if (r != 2) begin
        if (r == 0)       p = 64'h4020_0000_0000_0000;
        else if (r == 15) p = 64'h0013_0303_FFFF_FFFF;
        else              p = make_pkt(r % 4, r / 4, 2, 0, {8'(r), 24'($urandom)});
        expect_pkt(p);
        pesi[r] = 1'b1;
        pedi[r] = p;
      end
    end
    @(posedge clk); #1;
    pesi = '0;
    wait_drain(200);
    check("gather_drained", 64'(exp_q.size()), 64'd0);
    check("gather_r2_count", 64'(deliv_cnt[2] - snap2), 64'd15);
    check("gather_total", 64'(deliv_total - snap), 64'd15);

    // Backpressure at r5
    @(posedge clk); #1;
    pero[5] = 1'b0;
    snap = deliv_cnt[5];
    p = 64'h6011_0000_5555_5555;
    check("bp_dest", 64'(ref_dest(p)), 64'd5);
    expect_pkt(p);
    inject(0, p, cap);
    repeat (10) @(negedge clk);
    check("bp_held", 64'(deliv_cnt[5] - snap), 64'd0);
    check("bp_peri_r0", 64'(peri[0]), 64'd1);
    @(posedge clk); #1;
    pero[5] = 1'b1;
    cap = cyc;
    wait_peso(5, 3, at);
    check("bp_release", 64'(at - cap), 64'd1);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Out-of-range from r3 (dest_x = 4)
    @(posedge clk); #1;
    p = 64'h4010_0300_ABCD_0123;
    check("oor_model", 64'(ref_dest(p)), 64'hFFFF_FFFF_FFFF_FFFF);
    snap = deliv_total;
    inject(3, p, cap);
    @(negedge clk);
    check("oor_peri_r3", 64'(peri[3]), 64'd1);
    repeat (12) @(negedge clk);
    check("oor_no_delivery", 64'(deliv_total - snap), 64'd0);

    // Self-send at r10
    @(posedge clk); #1;
    p = 64'h0000_0202_1234_5678;
    expect_pkt(p);
    inject(10, p, cap);
    wait_peso(10, 5, at);
    check("self_latency", 64'(at - cap), 64'd1);
    check("self_drained", 64'(exp_q.size()), 64'd0);

    // Reset while a 6-hop packet is in flight
    @(posedge clk); #1;
    p = 64'h6033_0000_DEAD_BEEF;
    check("midrst_hops", 64'(ref_hops(p)), 64'd6);
    snap = deliv_total;
    inject(0, p, cap);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_peso", 64'(peso), 64'h0);
    check("midrst_polarity", 64'(polarity), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (16) @(negedge clk);
    check("midrst_no_delivery", 64'(deliv_total - snap), 64'd0);
    check("midrst_peri", 64'(peri), 64'hFFFF);

    // Random traffic with random PE backpressure
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      for (int r = 0; r < 16; r++) begin
        pero[r] = ($urandom_range(0, 3) != 0);
        pesi[r] = 1'b0;
        if (peri[r] && $urandom_range(0, 2) == 0) begin
          p = make_pkt(r % 4, r / 4, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
          if ($urandom_range(0, 7) == 0) begin
            p[62] = 1'b1;
            p[55:52] = 4'(4 - (r % 4) + $urandom_range(0, 3));
          end
          d = ref_dest(p);
          if (d >= 0) exp_q.push_back({4'(d), p});
          pesi[r] = 1'b1;
          pedi[r] = p;
        end
      end
    end
    @(posedge clk); #1;
    pesi = '0;
    pero = '1;
    wait_drain(300);
    check("random_drained", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge clk);
    check("final_peri", 64'(peri), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
